// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout game controller slice.
package breakout_pkg;

  localparam int unsigned NUM_COLS       = 5;
  localparam int unsigned BLOCKS_PER_COL = 8;
  localparam int unsigned COL_CNT_W      = 6;
  localparam int unsigned COL_IDX_W      = 3;
  localparam int unsigned SCORE_W        = 10;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StOver  = 3'd4,
    StWin   = 3'd5
  } state_e;

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Column bus between the block columns (master) and the game controller (slave):
// per-column bounce requests and cleared counts in, granted hit out.
interface breakout_game_ctrl_if #(
  parameter int unsigned NUM_COLS = breakout_pkg::NUM_COLS
);

  logic [NUM_COLS-1:0]                       col_moveU;
  logic [NUM_COLS-1:0]                       col_moveD;
  logic [NUM_COLS-1:0]                       col_moveL;
  logic [NUM_COLS-1:0]                       col_moveR;
  logic [breakout_pkg::COL_CNT_W*NUM_COLS-1:0] col_count;
  logic                                      hit_valid;
  logic [breakout_pkg::COL_IDX_W-1:0]        hit_col;

  modport master (
    output col_moveU, col_moveD, col_moveL, col_moveR, col_count,
    input  hit_valid, hit_col
  );

  modport slave (
    input  col_moveU, col_moveD, col_moveL, col_moveR, col_count,
    output hit_valid, hit_col
  );

endinterface

// File: rtl/breakout_hit_arb.sv
// Picks one requesting column per cycle. Fixed priority (lowest index) by default;
// round-robin with a next-start pointer when BREAKOUT_HIT_ARB_RR_EN is defined.
module breakout_hit_arb #(
  parameter int unsigned NUM_COLS = breakout_pkg::NUM_COLS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_COLS-1:0]                i_req,
  output logic                               o_valid,
  output logic [breakout_pkg::COL_IDX_W-1:0] o_idx
);
  import breakout_pkg::*;

`ifdef BREAKOUT_HIT_ARB_RR_EN
  // r_ptr is the column the next search starts from (last grant + 1).
  logic [COL_IDX_W-1:0] r_ptr;
  logic [COL_IDX_W-1:0] w_cand;
  int unsigned          w_j;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    w_j     = 0;
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      w_j    = (int unsigned'(r_ptr) + int unsigned'(k)) % NUM_COLS;
      w_cand = COL_IDX_W'(w_j);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_idx == COL_IDX_W'(NUM_COLS - 1)) ? '0 : o_idx + COL_IDX_W'(1);
    end
  end
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ reset;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_valid = 1'b1;
        o_idx   = COL_IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game controller: serve/play/miss FSM, lives, score and column hit grants.
// Define BREAKOUT_HIT_ARB_RR_EN for round-robin hit arbitration.
module breakout_game_ctrl #(
  parameter int unsigned NUM_COLS       = breakout_pkg::NUM_COLS,
  parameter int unsigned BLOCKS_PER_COL = breakout_pkg::BLOCKS_PER_COL,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned MISS_Y         = 470,
  parameter int unsigned SERVE_FRAMES   = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 frame_tick,
  input  logic [10:0]          ball_y_b,
  breakout_game_ctrl_if.slave  col_bus,
  output logic                 board_reset,
  output logic                 ball_reset,
  output logic                 ball_en,
  output logic                 dir_x,
  output logic                 dir_y,
  output logic [1:0]           lives,
  output logic [9:0]           score,
  output logic [2:0]           state
);
  import breakout_pkg::*;

  localparam int unsigned SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(NUM_COLS * BLOCKS_PER_COL);

  state_e               r_state;
  logic [1:0]           r_lives;
  logic [SCORE_W-1:0]   r_score;
  logic [SERVE_W-1:0]   r_serve_cnt;
  logic                 r_dir_x;
  logic                 r_dir_y;
  logic                 r_ball_en;
  logic                 r_ball_reset;
  logic                 r_board_reset;
  logic                 r_hit_valid;
  logic [COL_IDX_W-1:0] r_hit_col;

  logic [NUM_COLS-1:0]  w_req;
  logic                 w_gnt_valid;
  logic [COL_IDX_W-1:0] w_gnt_idx;
  logic [SCORE_W-1:0]   w_score_sum;
  logic                 w_miss;

  // Requests are masked outside PLAY so no grant (and no direction change) can occur.
  assign w_req = (col_bus.col_moveU | col_bus.col_moveD | col_bus.col_moveL | col_bus.col_moveR)
               & {NUM_COLS{r_state == StPlay}};
  assign w_miss = frame_tick && (ball_y_b >= 11'(MISS_Y));

  breakout_hit_arb #(
    .NUM_COLS (NUM_COLS)
  ) u_hit_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_req),
    .o_valid (w_gnt_valid),
    .o_idx   (w_gnt_idx)
  );

  always_comb begin
    w_score_sum = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      w_score_sum = w_score_sum + SCORE_W'(col_bus.col_count[COL_CNT_W*i +: COL_CNT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_score <= '0;
    else       r_score <= w_score_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_lives       <= '0;
      r_serve_cnt   <= '0;
      r_dir_x       <= 1'b1;
      r_dir_y       <= 1'b0;
      r_ball_en     <= 1'b0;
      r_ball_reset  <= 1'b0;
      r_board_reset <= 1'b1;
      r_hit_valid   <= 1'b0;
      r_hit_col     <= '0;
    end else begin
      r_ball_reset <= 1'b0;
      r_hit_valid  <= 1'b0;
      // Absolute writes; opposing bits on the same axis leave that axis alone.
      if (w_gnt_valid) begin
        r_hit_valid <= 1'b1;
        r_hit_col   <= w_gnt_idx;
        if (col_bus.col_moveU[w_gnt_idx] != col_bus.col_moveD[w_gnt_idx]) begin
          r_dir_y <= col_bus.col_moveD[w_gnt_idx];
        end
        if (col_bus.col_moveL[w_gnt_idx] != col_bus.col_moveR[w_gnt_idx]) begin
          r_dir_x <= col_bus.col_moveR[w_gnt_idx];
        end
      end
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state       <= StServe;
            r_lives       <= 2'(LIVES);
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b0;
            r_ball_reset  <= 1'b1;
            r_board_reset <= 1'b0;
          end
        end
        StServe: begin
          if (frame_tick) begin
            if (r_serve_cnt == SERVE_W'(SERVE_FRAMES - 1)) begin
              r_state     <= StPlay;
              r_serve_cnt <= '0;
              r_ball_en   <= 1'b1;
            end else begin
              r_serve_cnt <= r_serve_cnt + SERVE_W'(1);
            end
          end
        end
        StPlay: begin
          if (r_score == WIN_SCORE) begin
            r_state   <= StWin;
            r_ball_en <= 1'b0;
          end else if (w_miss) begin
            r_state   <= StMiss;
            r_ball_en <= 1'b0;
          end
        end
        StMiss: begin
          r_lives      <= r_lives - 2'd1;
          r_ball_reset <= 1'b1;
          r_state      <= (r_lives == 2'd1) ? StOver : StServe;
        end
        StOver, StWin: begin
          if (start) begin
            r_state       <= StIdle;
            r_board_reset <= 1'b1;
          end
        end
        default: begin
          r_state       <= StIdle;
          r_ball_en     <= 1'b0;
          r_board_reset <= 1'b1;
        end
      endcase
    end
  end

  assign col_bus.hit_valid = r_hit_valid;
  assign col_bus.hit_col   = r_hit_col;
  assign board_reset       = r_board_reset;
  assign ball_reset        = r_ball_reset;
  assign ball_en           = r_ball_en;
  assign dir_x             = r_dir_x;
  assign dir_y             = r_dir_y;
  assign lives             = r_lives;
  assign score             = r_score;
  assign state             = r_state;

endmodule
